// File: rtl/mem_store_buffer.sv
// Store buffer between MEM and data_memory; load forwarding enabled by MEM_STORE_BUFFER_FORWARD_EN.
// Latency: a store pushed at edge N may drain in cycle N+1; ld_hit and dm_* are combinational.
// Backpressure: st_ready drops when full or draining; loads own the memory port while dm_busy is high.
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    input  logic [AW-1:0]          st_addr,
    input  logic [DW-1:0]          st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_addr,
    output logic                   ld_hit,
    output logic [DW-1:0]          ld_fwd_data,
    output logic                   stall,
    input  logic                   dm_busy,
    output logic                   dm_mem_write,
    output logic [AW-1:0]          dm_address,
    output logic [DW-1:0]          dm_write_data,
    input  logic                   drain,
    output logic                   drain_done,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state_q;
    logic              drain_done_q;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]     count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [AW-1:0]     addr_q [DEPTH];
    logic [AW-1:0]     addr_d [DEPTH];
    logic [DW-1:0]     data_q [DEPTH];
    logic [DW-1:0]     data_d [DEPTH];
    logic              full, push, pop, ld_block;
    logic              match_any;
    logic [IW-1:0]     scan_idx;

    // Wrap bit distinguishes full from empty when the index bits coincide.
    assign full  = (head_q[PW-1] != tail_q[PW-1]) && (head_q[IW-1:0] == tail_q[IW-1:0]);
    assign empty = (head_q == tail_q);
    assign count = tail_q - head_q;

    assign st_ready     = !full && (state_q == RUN);
    assign push         = st_valid && st_ready;
    assign dm_mem_write = !empty && !dm_busy;
    assign pop          = dm_mem_write;

    assign dm_address    = addr_q[head_q[IW-1:0]];
    assign dm_write_data = data_q[head_q[IW-1:0]];
    assign drain_done    = drain_done_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop) begin
            valid_d[head_q[IW-1:0]] = 1'b0;
            head_d                  = head_q + PW'(1);
        end
        if (push) begin
            valid_d[tail_q[IW-1:0]] = 1'b1;
            addr_d[tail_q[IW-1:0]]  = st_addr;
            data_d[tail_q[IW-1:0]]  = st_data;
            tail_d                  = tail_q + PW'(1);
        end
        count_d = tail_d - head_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (drain) begin
                        if (empty) drain_done_q <= 1'b1;
                        else       state_q      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_d == '0) begin
                        state_q      <= RUN;
                        drain_done_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef MEM_STORE_BUFFER_FORWARD_EN
    logic [DW-1:0] fwd_data;

    // Scan oldest to youngest so the entry nearest tail overrides older matches.
    always_comb begin
        match_any = 1'b0;
        fwd_data  = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q[IW-1:0] + IW'(i);
            if (valid_q[scan_idx] && (addr_q[scan_idx] == ld_addr)) begin
                match_any = 1'b1;
                fwd_data  = data_q[scan_idx];
            end
        end
    end

    assign ld_hit      = ld_valid && match_any;
    assign ld_fwd_data = ld_hit ? fwd_data : '0;
    assign ld_block    = 1'b0;
`else
    always_comb begin
        match_any = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = IW'(i);
            if (valid_q[scan_idx] && (addr_q[scan_idx] == ld_addr)) match_any = 1'b1;
        end
    end

    // Without forwarding a matching load must wait until the store reaches memory.
    assign ld_hit      = 1'b0;
    assign ld_fwd_data = '0;
    assign ld_block    = ld_valid && match_any;
`endif

    assign stall = (st_valid && !st_ready) || (ld_valid && st_valid) || ld_block;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: a queue model predicts every output each cycle,
// and scenario tasks add targeted checks for ordering, backpressure, forwarding, drain and reset.
`timescale 1ns/1ps
module tb_mem_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
`ifdef MEM_STORE_BUFFER_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          st_valid = 1'b0, ld_valid = 1'b0, dm_busy = 1'b0, drain = 1'b0;
    logic [AW-1:0] st_addr = '0, ld_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic          st_ready, ld_hit, stall, dm_mem_write, drain_done, empty;
    logic [DW-1:0] ld_fwd_data, dm_write_data;
    logic [AW-1:0] dm_address;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    mem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
        .stall(stall), .dm_busy(dm_busy), .dm_mem_write(dm_mem_write),
        .dm_address(dm_address), .dm_write_data(dm_write_data),
        .drain(drain), .drain_done(drain_done), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t mq[$];
    bit   mdrain = 1'b0;
    bit   edone  = 1'b0;
    int   sz;
    bit   acc, pp, old_dr, edn;

    // Reference model advanced on every rising edge from the inputs held across it.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mdrain = 1'b0;
            edone  = 1'b0;
        end else begin
            sz     = mq.size();
            old_dr = mdrain;
            acc    = st_valid && (sz < DEPTH) && !old_dr;
            pp     = (sz > 0) && !dm_busy;
            edn    = 1'b0;
            if (pp)  void'(mq.pop_front());
            if (acc) mq.push_back({st_addr, st_data});
            if (!old_dr && drain) begin
                if (sz == 0) edn = 1'b1;
                else         mdrain = 1'b1;
            end
            if (old_dr && (mq.size() == 0)) begin
                mdrain = 1'b0;
                edn    = 1'b1;
            end
            edone = edn;
        end
    end

    bit            exp_rdy, exp_wr, found, exp_hit, exp_stall;
    logic [DW-1:0] fdat, exp_fdat;

    always @(negedge clk) begin
        if (!reset) begin
            exp_rdy = (mq.size() < DEPTH) && !mdrain;
            exp_wr  = (mq.size() > 0) && !dm_busy;
            found   = 1'b0;
            fdat    = '0;
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].a == ld_addr) begin found = 1'b1; fdat = mq[i].d; end
            exp_hit   = FWD && ld_valid && found;
            exp_fdat  = exp_hit ? fdat : '0;
            exp_stall = (st_valid && !exp_rdy) || (ld_valid && st_valid) || (!FWD && ld_valid && found);
            checks++; if (st_ready !== exp_rdy) begin errors++; $display("FAIL mon_st_ready got %b exp %b t=%0t", st_ready, exp_rdy, $time); end
            checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL mon_count got %0d exp %0d t=%0t", count, mq.size(), $time); end
            checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL mon_empty got %b exp %b t=%0t", empty, mq.size() == 0, $time); end
            checks++; if (dm_mem_write !== exp_wr) begin errors++; $display("FAIL mon_dm_mem_write got %b exp %b t=%0t", dm_mem_write, exp_wr, $time); end
            if (exp_wr) begin
                checks++; if (dm_address !== mq[0].a) begin errors++; $display("FAIL mon_dm_address got %h exp %h t=%0t", dm_address, mq[0].a, $time); end
                checks++; if (dm_write_data !== mq[0].d) begin errors++; $display("FAIL mon_dm_write_data got %h exp %h t=%0t", dm_write_data, mq[0].d, $time); end
            end
            checks++; if (drain_done !== edone) begin errors++; $display("FAIL mon_drain_done got %b exp %b t=%0t", drain_done, edone, $time); end
            checks++; if (ld_hit !== exp_hit) begin errors++; $display("FAIL mon_ld_hit got %b exp %b t=%0t", ld_hit, exp_hit, $time); end
            checks++; if (ld_fwd_data !== exp_fdat) begin errors++; $display("FAIL mon_ld_fwd_data got %h exp %h t=%0t", ld_fwd_data, exp_fdat, $time); end
            checks++; if (stall !== exp_stall) begin errors++; $display("FAIL mon_stall got %b exp %b t=%0t", stall, exp_stall, $time); end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string nm);
        bit ok = 1'b0;
        #1;
        st_valid = 1'b0; ld_valid = 1'b0; dm_busy = 1'b0; drain = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            step();
            @(negedge clk);
            if (empty === 1'b1) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL %s_drain_timeout empty=%b count=%0d exp empty", nm, empty, count); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b exp 1", st_ready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ld_hit got %b exp 0", ld_hit); end
        checks++; if (ld_fwd_data !== 32'h0) begin errors++; $display("FAIL reset_ld_fwd_data got %h exp 0", ld_fwd_data); end
        checks++; if (dm_mem_write !== 1'b0) begin errors++; $display("FAIL reset_dm_mem_write got %b exp 0", dm_mem_write); end
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done got %b exp 0", drain_done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        #1 reset = 1'b0;
    endtask

    task automatic test_basic_order();
        step(); dm_busy = 1'b0; st_valid = 1'b1; st_addr = 32'h7FFFFF00; st_data = 32'h11;
        step(); st_addr = 32'h7FFFFF04; st_data = 32'h22;
        @(negedge clk);
        checks++; if (dm_mem_write !== 1'b1 || dm_address !== 32'h7FFFFF00 || dm_write_data !== 32'h11) begin
            errors++; $display("FAIL basic_first_write got we=%b %h/%h exp 1 7fffff00/11", dm_mem_write, dm_address, dm_write_data); end
        step(); st_valid = 1'b0;
        @(negedge clk);
        checks++; if (dm_mem_write !== 1'b1 || dm_address !== 32'h7FFFFF04 || dm_write_data !== 32'h22) begin
            errors++; $display("FAIL basic_second_write got we=%b %h/%h exp 1 7fffff04/22", dm_mem_write, dm_address, dm_write_data); end
        step();
        @(negedge clk);
        checks++; if (empty !== 1'b1 || count !== 3'd0 || dm_mem_write !== 1'b0) begin
            errors++; $display("FAIL basic_final got empty=%b count=%0d we=%b exp 1 0 0", empty, count, dm_mem_write); end
    endtask

    task automatic test_full();
        step(); dm_busy = 1'b1; st_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_addr = 32'h7FFFFF80 + 32'(i * 4); st_data = 32'h100 + 32'(i);
            step();
        end
        st_addr = 32'h7FFFFF90; st_data = 32'h104;
        @(negedge clk);
        checks++; if (st_ready !== 1'b0 || stall !== 1'b1 || count !== 3'd4) begin
            errors++; $display("FAIL full_fifth_refused got rdy=%b stall=%b count=%0d exp 0 1 4", st_ready, stall, count); end
        step(); dm_busy = 1'b0;
        @(negedge clk);
        checks++; if (st_ready !== 1'b0 || dm_mem_write !== 1'b1) begin
            errors++; $display("FAIL full_pop_no_slot got rdy=%b we=%b exp 0 1", st_ready, dm_mem_write); end
        step();
        @(negedge clk);
        checks++; if (st_ready !== 1'b1 || count !== 3'd3) begin
            errors++; $display("FAIL full_slot_freed got rdy=%b count=%0d exp 1 3", st_ready, count); end
        wait_empty("full");
    endtask

    task automatic test_forward();
        bit            e_stall, e_hit;
        logic [DW-1:0] e_data;
        step(); dm_busy = 1'b1; st_valid = 1'b1; st_addr = 32'h7FFFFF10; st_data = 32'hAA;
        step(); st_data = 32'hBB;
        step(); st_addr = 32'h7FFFFF14; st_data = 32'hCC;
        step(); st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h7FFFFF10;
        @(negedge clk);
        checks++; if (ld_hit !== FWD || ld_fwd_data !== (FWD ? 32'hBB : 32'h0) || stall !== !FWD) begin
            errors++; $display("FAIL fwd_youngest got hit=%b data=%h stall=%b exp %b %h %b", ld_hit, ld_fwd_data, stall, FWD, FWD ? 32'hBB : 32'h0, !FWD); end
        step(); ld_addr = 32'h7FFFFF11;
        @(negedge clk);
        checks++; if (ld_hit !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL fwd_miss got hit=%b stall=%b exp 0 0", ld_hit, stall); end
        step(); ld_addr = 32'h7FFFFF10; dm_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e_hit   = FWD && (k < 2);
            e_data  = e_hit ? 32'hBB : 32'h0;
            e_stall = !FWD && (k < 2);
            @(negedge clk);
            checks++; if (ld_hit !== e_hit || ld_fwd_data !== e_data || stall !== e_stall) begin
                errors++; $display("FAIL fwd_during_pop_%0d got hit=%b data=%h stall=%b exp %b %h %b", k, ld_hit, ld_fwd_data, stall, e_hit, e_data, e_stall); end
            step();
        end
        wait_empty("forward");
    endtask

    task automatic test_same_cycle();
        step(); dm_busy = 1'b1; st_valid = 1'b1; ld_valid = 1'b1;
        st_addr = 32'h7FFFFF20; st_data = 32'h55; ld_addr = 32'h7FFFFF20;
        @(negedge clk);
        checks++; if (stall !== 1'b1 || ld_hit !== 1'b0 || st_ready !== 1'b1 || count !== 3'd0) begin
            errors++; $display("FAIL same_cycle got stall=%b hit=%b rdy=%b count=%0d exp 1 0 1 0", stall, ld_hit, st_ready, count); end
        step(); st_valid = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL same_cycle_count got %0d exp 1", count); end
        step(); ld_valid = 1'b1;
        @(negedge clk);
        checks++; if (ld_hit !== FWD || ld_fwd_data !== (FWD ? 32'h55 : 32'h0) || stall !== !FWD) begin
            errors++; $display("FAIL same_cycle_reissue got hit=%b data=%h stall=%b exp %b %h %b", ld_hit, ld_fwd_data, stall, FWD, FWD ? 32'h55 : 32'h0, !FWD); end
        wait_empty("same_cycle");
    endtask

    task automatic test_drain();
        int last_pop = -1;
        int done_cyc = -1;
        int ndone    = 0;
        step(); dm_busy = 1'b1; st_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_addr = 32'h7FFFFF60 + 32'(i * 4); st_data = 32'h200 + 32'(i);
            step();
        end
        st_valid = 1'b0; drain = 1'b1;
        step(); drain = 1'b0; st_valid = 1'b1; st_addr = 32'h7FFFFF70; st_data = 32'h2FF;
        @(negedge clk);
        checks++; if (st_ready !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL drain_refuse got rdy=%b stall=%b exp 0 1", st_ready, stall); end
        step(); dm_busy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ndone == 0 && dm_mem_write === 1'b1 && count === 3'd1) last_pop = k;
            if (drain_done === 1'b1) begin ndone++; done_cyc = k; #1 st_valid = 1'b0; end
            step();
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL drain_done_pulses got %0d exp 1", ndone); end
        checks++; if (last_pop < 0 || done_cyc != last_pop + 1) begin
            errors++; $display("FAIL drain_done_timing got cycle %0d exp %0d", done_cyc, last_pop + 1); end
        wait_empty("drain");
    endtask

    task automatic test_async_reset();
        step(); dm_busy = 1'b1; st_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_addr = 32'h7FFFFF40 + 32'(i * 4); st_data = 32'h300 + 32'(i);
            step();
        end
        st_valid = 1'b0; drain = 1'b1;
        step(); drain = 1'b0;
        #2 reset = 1'b1;
        mq.delete(); mdrain = 1'b0; edone = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset_state got count=%0d empty=%b rdy=%b exp 0 1 1", count, empty, st_ready); end
        checks++; if (dm_mem_write !== 1'b0 || drain_done !== 1'b0 || stall !== 1'b0 || ld_hit !== 1'b0) begin
            errors++; $display("FAIL async_reset_outputs got we=%b done=%b stall=%b hit=%b exp 0 0 0 0", dm_mem_write, drain_done, stall, ld_hit); end
        @(negedge clk);
        #1 reset = 1'b0; dm_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (dm_mem_write !== 1'b0 || count !== 3'd0) begin
                errors++; $display("FAIL async_reset_after_%0d got we=%b count=%0d exp 0 0", k, dm_mem_write, count); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_order();
        test_full();
        test_forward();
        test_same_cycle();
        test_drain();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
